// File: rtl/muldiv_unit_if.sv
// Execute-stage <-> multiply/divide unit interface: issue handshake, operands and HI/LO results.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, rs, rt, flush,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, rs, rt, flush,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO (shift-add multiply, restoring divide).
// Optional MULDIV_EARLY_OUT_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;      // product, or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     opb_q, opb_d;      // multiplier (shifted right) or divisor
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic                 signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   prod_nxt, prod_fix;
    logic [WIDTH-1:0]     mplr_nxt;
    logic [WIDTH:0]       rem_sh;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_new, quot_fix, rem_fix;
    logic [2*WIDTH-1:0]   div_nxt;
    logic                 last_iter, early_out;

    assign signed_op = !bus.op[0];
    assign a_neg     = signed_op & bus.rs[WIDTH-1];
    assign b_neg     = signed_op & bus.rt[WIDTH-1];
    assign abs_a     = a_neg ? -bus.rs : bus.rs;
    assign abs_b     = b_neg ? -bus.rt : bus.rt;

    assign prod_nxt  = acc_q + (opb_q[0] ? mcand_q : '0);
    assign mplr_nxt  = opb_q >> 1;

    // Remainder after subtract is below the divisor, so modulo-2^WIDTH arithmetic suffices.
    assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_ge    = rem_sh >= {1'b0, opb_q};
    assign rem_new   = rem_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];
    assign div_nxt   = {rem_new, acc_q[WIDTH-2:0], rem_ge};

    assign prod_fix  = neg_lo_q ? -acc_q : acc_q;
    assign quot_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    assign last_iter = cnt_q == CNT_W'(WIDTH - 1);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = !is_div_q && (mplr_nxt == '0);
`else
    assign early_out = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.start && !bus.flush && !bus.op[2]) state_d = StRun;
            StRun: begin
                if (bus.flush) state_d = StIdle;
                else if (last_iter || early_out) state_d = StFix;
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy     = state_q != StIdle;
        bus.done     = done_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
        bus.div_zero = div_zero_q;
    end

    always_comb begin
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.flush) begin
                    if (!bus.op[2]) begin
                        acc_d    = bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        opb_d    = abs_b;
                        cnt_d    = '0;
                        is_div_d = bus.op[1];
                        neg_lo_d = a_neg ^ b_neg;
                        neg_hi_d = a_neg;
                        dz_d     = bus.rt == '0;
                    end else if (bus.op[1:0] == 2'b00) begin
                        hi_d = bus.rs;
                    end else if (bus.op[1:0] == 2'b01) begin
                        lo_d = bus.rs;
                    end
                end
            end
            StRun: begin
                if (!bus.flush) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = div_nxt;
                    end else begin
                        acc_d   = prod_nxt;
                        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                        opb_d   = mplr_nxt;
                    end
                end
            end
            StFix: begin
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Zero divisor leaves the dividend in the remainder, so hi == original rs.
                        hi_d       = rem_fix;
                        lo_d       = dz_q ? '1 : quot_fix;
                        div_zero_d = dz_q;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q      <= '0;
            mcand_q    <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            opb_q      <= opb_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): expected results queued at issue, checked on done.
module tb_muldiv_unit;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs    = a;
        bus.rt    = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts negedges with busy high after an issue; returns at the first idle negedge.
    task automatic count_busy(output int n);
        n = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (!bus.busy) return;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        count_busy(n);
        if (n >= 100) chk("wait_idle_timeout", 64'(n), 64'(0));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("done_hi", 64'(bus.hi), 64'(e.hi));
                    chk("done_lo", 64'(bus.lo), 64'(e.lo));
                    chk("done_div_zero", 64'(bus.div_zero), 64'(e.dz));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b110;
        bus.rs    = '0;
        bus.rt    = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", 64'(bus.hi), 64'(0));
        chk("reset_lo", 64'(bus.lo), 64'(0));
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_div_zero", 64'(bus.div_zero), 64'(0));

        // MULT -3 * 7, with busy duration and hi/lo hold checks
        exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dz: 1'b0});
        @(posedge clk); #1;
        issue(3'b000, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        chk("run_hi_hold", 64'(bus.hi), 64'(0));
        n = 1;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        chk("mult_busy_cycles", 64'(n), 64'(33));
        chk("mult_done_at_idle", 64'(bus.done), 64'(1));

        // MULTU max*max, DIV issued back-to-back by holding start through busy
        exp_q.push_back('{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dz: 1'b0});
        exp_q.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dz: 1'b0});
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.rs    = 32'hFFFF_FFF9;
        bus.rt    = 32'd2;
        n = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (bus.done) break;
            n++;
        end
        chk("b2b_multu_wait", 64'(n), 64'(32));
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rs    = 32'h55;
        bus.rt    = 32'h0;
        @(negedge clk);
        chk("b2b_div_accepted", 64'(bus.busy), 64'(1));
        wait_idle();

        // DIVU by zero, then MULTU keeps the sticky flag, then DIV MIN/-1 clears it
        exp_q.push_back('{hi: 32'd100, lo: 32'hFFFF_FFFF, dz: 1'b1});
        issue(3'b011, 32'd100, 32'd0);
        wait_idle();
        exp_q.push_back('{hi: 32'h0000_0001, lo: 32'h2345_6780, dz: 1'b1});
        issue(3'b001, 32'h1234_5678, 32'h10);
        wait_idle();
        exp_q.push_back('{hi: 32'h0, lo: 32'h8000_0000, dz: 1'b0});
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();

        // MTHI then MTLO on consecutive idle cycles
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.rs    = 32'h1234;
        @(posedge clk); #1;
        bus.op    = 3'b101;
        bus.rs    = 32'h5678;
        @(negedge clk);
        chk("mthi_hi", 64'(bus.hi), 64'(32'h1234));
        chk("mthi_lo_kept", 64'(bus.lo), 64'(32'h8000_0000));
        chk("mthi_busy", 64'(bus.busy), 64'(0));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", 64'(bus.lo), 64'(32'h5678));
        chk("mtlo_hi_kept", 64'(bus.hi), 64'(32'h1234));

        // Flush on RUN cycle 10: no done, hi/lo untouched
        issue(3'b000, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(bus.busy), 64'(0));
        repeat (40) @(negedge clk);
        chk("flush_hi", 64'(bus.hi), 64'(32'h1234));
        chk("flush_lo", 64'(bus.lo), 64'(32'h5678));

        // flush with start in IDLE ignores the start
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.rs    = 32'hDEAD;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_start_ignored", 64'(bus.hi), 64'(32'h1234));

        // Reset in the middle of a DIV
        issue(3'b010, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_hi", 64'(bus.hi), 64'(0));
        chk("rst_mid_lo", 64'(bus.lo), 64'(0));
        chk("rst_mid_busy", 64'(bus.busy), 64'(0));
        repeat (40) @(negedge clk);

        // MULTU 9 * 1: early-out shortens busy to two cycles when enabled
        exp_q.push_back('{hi: 32'h0, lo: 32'd9, dz: 1'b0});
        @(posedge clk); #1;
        issue(3'b001, 32'd9, 32'd1);
        count_busy(n);
`ifdef MULDIV_EARLY_OUT_EN
        chk("multu_rt1_busy", 64'(n), 64'(2));
`else
        chk("multu_rt1_busy", 64'(n), 64'(33));
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit owning the architectural HI/LO registers. It replaces the combinational, latch-prone hi/lo handling inside the execute stage.
- Execute issues MULT/MULTU/DIV/DIVU/MTHI/MTLO via a start pulse and stalls on busy. MFHI/MFLO read the hi/lo outputs directly.
- Iterative radix-2 datapath: shift-add multiply, restoring divide. Supports signed and unsigned modes and pipeline flush.

Parameters:
- WIDTH, 32, operand width and width of each of hi/lo (legal: 8..64, even).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue request, sampled only when busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- rs  in  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO data)
- rt  in  WIDTH  operand B (multiplier / divisor)
- flush  in  1  cancel in-flight op
- busy  out  1  operation in progress; execute stalls
- done  out  1  one-cycle pulse, hi/lo just updated by mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- div_zero  out  1  sticky: last completed DIV/DIVU had rt=0

Behaviour:
- Reset: hi=0, lo=0, busy=0, done=0, div_zero=0, FSM=IDLE. Reset during RUN or FIX aborts with no writeback.
- FSM states: IDLE, RUN, FIX.
  - IDLE, start=1, op in 000..011: latch |rs|,|rt| (signed ops) or raw values (unsigned ops), result signs, and op. Clear counter. Go to RUN. busy=1 from the next cycle.
  - IDLE, start=1, op=100/101: hi (resp. lo) <= rs at that edge. Stay IDLE, no done, busy stays 0.
  - IDLE, op=110/111: ignored.
  - RUN: one iteration per cycle for exactly WIDTH cycles, then go to FIX.
    - Multiply: 2*WIDTH-bit accumulator; add the multiplicand if the current multiplier LSB is 1, then shift.
    - Divide: shift in the next dividend bit; subtract the divisor if the remainder >= divisor; quotient bit = 1 on subtract.
  - FIX, one cycle: apply sign correction.
    - Multiply: negate the 2*WIDTH product if signs differ. hi=upper half, lo=lower half.
    - Divide: lo=quotient, negated if sign(rs)^sign(rt); hi=remainder, negated if sign(rs).
    - At the FIX edge: hi/lo written, done=1 for one cycle, busy=0, go to IDLE.
- Latency: start accepted at edge E0. hi/lo/done valid after edge E0+WIDTH+1. busy is high for WIDTH+1 cycles.
- Back-to-back issue: start in the cycle where done=1 is accepted.
- start while busy=1: ignored, not queued. Execute must hold the request.
- hi/lo hold their old values throughout RUN/FIX.
- Divide by zero (rt=0, DIV or DIVU): at FIX, hi=original rs, lo=all ones, div_zero=1. Latency is unchanged.
- div_zero is cleared by the next completed DIV/DIVU with rt!=0.
- Signed DIV of MIN by -1: lo=MIN (e.g. 0x80000000), hi=0. No exception.
- flush=1 in RUN or FIX: return to IDLE next edge, busy=0, no done, hi/lo/div_zero unchanged.
- flush in IDLE: no effect. flush together with start in IDLE: start is ignored.
- Operands are captured at issue; rs/rt changes during RUN have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: multiply leaves RUN as soon as the remaining shifted multiplier bits are all zero (minimum 1 RUN cycle). Its latency becomes (index of highest set bit of |rt|)+3 cycles; rt=0 completes in 3 cycles. Divide latency is unchanged. done/busy semantics are identical.
- Undefined: fixed WIDTH+2 latency for all mul/div ops; the early-out logic is absent.

Test Plan:
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU rs=100, rt=0 -> hi=100, lo=0xFFFFFFFF, div_zero=1.
- MTHI rs=0x1234 then MTLO rs=0x5678 on consecutive idle cycles -> hi=0x1234, lo=0x5678 after each edge, done never asserted.
- Flush: start MULT 5*5, assert flush on RUN cycle 10 -> busy drops next edge, no done, hi/lo keep prior values. Reset mid-DIV -> hi=lo=0, busy=0.
- Back-to-back plus ignored start: start re-asserted during busy has no effect. Start asserted with done=1 is accepted. With MULDIV_EARLY_OUT_EN, MULTU rt=1 completes in 3 cycles.
